// File: rtl/sample_timing_pkg.sv
// rtl/sample_timing_pkg.sv - shared state type and sizing helpers for sample_timing_gen
package sample_timing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HUNT  = 2'd1,
    TRACK = 2'd2
  } state_t;

  function automatic int half_of(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

  function automatic int phase_w(input int clks_per_bit);
    return $clog2(clks_per_bit);
  endfunction

  function automatic int run_w(input int max_run);
    return $clog2(max_run + 1);
  endfunction

endpackage

// File: rtl/sample_timing_gen_bit_sync.sv
// rtl/sample_timing_gen_bit_sync.sv - N-stage async-reset synchroniser exposing its last TAPS stages
module bit_sync #(
  parameter int STAGES = 2,
  parameter int TAPS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            d,
  output logic [TAPS-1:0] q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // q[TAPS-1] is the oldest stage
  assign q = sync_q[STAGES-1 -: TAPS];

endmodule

// File: rtl/sample_timing_gen.sv
// rtl/sample_timing_gen.sv - bit-centre sample pulse generator; SAMPLE_GLITCH_FILTER_EN adds 1-clock glitch rejection
module sample_timing_gen
  import sample_timing_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100,
  parameter int MAX_RUN      = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            dInRaw,
  output logic                            dOut,
  output logic                            samplePulse,
  output logic                            locked,
  output logic [$clog2(CLKS_PER_BIT)-1:0] bitPhase
);

  localparam int HALF = half_of(CLKS_PER_BIT);
  localparam int PW   = phase_w(CLKS_PER_BIT);
  localparam int RW   = run_w(MAX_RUN);

  localparam logic [PW-1:0] PHASE_LAST   = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PHASE_SAMPLE = PW'(HALF - 1);
  localparam logic [RW-1:0] RUN_LAST     = RW'(MAX_RUN - 1);
  localparam logic [RW-1:0] RUN_MAX      = '1;

  logic data_edge;

`ifdef SAMPLE_GLITCH_FILTER_EN
  logic [1:0] taps;
  logic       lvl_q, lvl_d;

  bit_sync #(.STAGES(3), .TAPS(2)) u_sync (
    .clk (clk),
    .rst (reset),
    .d   (dInRaw),
    .q   (taps)
  );

  // lvl_q only follows the line once two consecutive stages agree
  always_comb begin
    lvl_d     = lvl_q;
    data_edge = 1'b0;
    if (taps[0] == taps[1]) begin
      lvl_d     = taps[1];
      data_edge = (taps[1] != lvl_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_q <= 1'b0;
    end else begin
      lvl_q <= lvl_d;
    end
  end

  assign dOut = taps[1];
`else
  logic s2;
  logic s3_q, s3_d;

  bit_sync #(.STAGES(2), .TAPS(1)) u_sync (
    .clk (clk),
    .rst (reset),
    .d   (dInRaw),
    .q   (s2)
  );

  always_comb begin
    s3_d      = s2;
    data_edge = s2 ^ s3_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_q <= 1'b0;
    end else begin
      s3_q <= s3_d;
    end
  end

  assign dOut = s2;
`endif

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [RW-1:0] run_q, run_d;
  logic          pulse_q, pulse_d;
  logic          locked_q, locked_d;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    run_d   = run_q;
    unique case (state_q)
      IDLE: begin
        phase_d = '0;
        run_d   = '0;
        if (enable) state_d = HUNT;
      end
      HUNT: begin
        phase_d = '0;
        run_d   = '0;
        if (data_edge) state_d = TRACK;
      end
      TRACK: begin
        if (data_edge) begin
          phase_d = '0;
          run_d   = '0;
        end else if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          if (run_q == RUN_LAST) begin
            state_d = HUNT;
            run_d   = '0;
          end else if (run_q != RUN_MAX) begin
            run_d = run_q + RW'(1);
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
        run_d   = '0;
      end
    endcase
    if (!enable) begin
      state_d = IDLE;
      phase_d = '0;
      run_d   = '0;
    end
    // an edge landing on the sample slot re-aligns instead of sampling
    pulse_d  = (state_q == TRACK) && !data_edge && (phase_q == PHASE_SAMPLE) && enable;
    locked_d = (state_d == TRACK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      run_q    <= '0;
      pulse_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      run_q    <= run_d;
      pulse_q  <= pulse_d;
      locked_q <= locked_d;
    end
  end

  assign samplePulse = pulse_q;
  assign locked      = locked_q;
  assign bitPhase    = phase_q;

endmodule
